// File: rtl/cozy_exec_ctrl_pkg.sv
// Shared definitions for the cozy execute-stage controller: ALU op codes,
// instruction word layout, FSM state encodings and register index helpers.
package cozy_exec_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0,
    OP_ADD = 4'h1,
    OP_ADC = 4'h2,
    OP_SUB = 4'h3,
    OP_SBC = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_NOT = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA,
    OP_ROL = 4'hB,
    OP_ROR = 4'hC,
    OP_INC = 4'hD,
    OP_NEG = 4'hE,
    OP_NOP = 4'hF
  } alu_op_e;

  // Instruction word, MSB first: [15:11] reserved, [10] no-write, [9:7] rS, [6:4] rD, [3:0] op
  typedef struct packed {
    logic [4:0] rsvd;
    logic       no_write;
    logic [2:0] rs;
    logic [2:0] rd;
    logic [3:0] op;
  } instr_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  // Register indices wrap modulo the (power-of-two) register count
  function automatic logic [2:0] wrap_idx(input logic [2:0] idx, input int nregs);
    return idx & 3'(nregs - 1);
  endfunction

endpackage

// File: rtl/cozy_regfile.sv
// NREGS x WIDTH register file: async clear, two operand read ports, one debug
// read port and a single synchronous write port.
module cozy_regfile
  import cozy_exec_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       addr_a,
  input  logic [2:0]       addr_b,
  input  logic [2:0]       dbg_addr,
  input  logic             we,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem [NREGS];

  assign data_a   = mem[wrap_idx(addr_a, NREGS)];
  assign data_b   = mem[wrap_idx(addr_b, NREGS)];
  assign dbg_data = mem[wrap_idx(dbg_addr, NREGS)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wrap_idx(wr_addr, NREGS)] <= wr_data;
    end
  end

endmodule

// File: rtl/cozy_exec_ctrl.sv
// Execute-stage controller driving the cozy ALU: IDLE -> READ -> EXEC -> WB.
// Optional zero flag output is enabled by defining COZY_EXEC_ZFLAG_EN.
module cozy_exec_ctrl
  import cozy_exec_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_rD,
  output logic [WIDTH-1:0] alu_rS,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry_out,
  output logic             done,
  output logic             err,
  output logic             carry,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`ifdef COZY_EXEC_ZFLAG_EN
  ,
  output logic             zero
`endif
);

  logic [1:0]       state;
  instr_t           dec;
  logic [3:0]       op_q;
  logic [2:0]       rd_q;
  logic [2:0]       rs_q;
  logic             no_write_q;
  logic [WIDTH-1:0] result;
  logic             result_carry;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] rs_data;
  logic             is_nop;
  logic             wb_write;

  assign dec          = in_instr;
  assign in_ready     = (state == ST_IDLE);
  assign alu_carry_in = carry;
  assign is_nop       = (op_q == OP_NOP);
  assign wb_write     = (state == ST_WB) && !no_write_q && !is_nop;

  cozy_regfile #(
    .NREGS (NREGS),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr_a   (rd_q),
    .addr_b   (rs_q),
    .dbg_addr (dbg_addr),
    .we       (wb_write),
    .wr_addr  (rd_q),
    .wr_data  (result),
    .data_a   (rd_data),
    .data_b   (rs_data),
    .dbg_data (dbg_data)
  );

  // A word with reserved bits set is rejected in IDLE without leaving it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      no_write_q   <= 1'b0;
      alu_op       <= '0;
      alu_rD       <= '0;
      alu_rS       <= '0;
      result       <= '0;
      result_carry <= 1'b0;
      carry        <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (dec.rsvd != '0) begin
              err <= 1'b1;
            end else begin
              op_q       <= dec.op;
              rd_q       <= dec.rd;
              rs_q       <= dec.rs;
              no_write_q <= dec.no_write;
              state      <= ST_READ;
            end
          end
        end
        ST_READ: begin
          alu_rD <= rd_data;
          alu_rS <= rs_data;
          alu_op <= op_q;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          result       <= alu_out;
          result_carry <= alu_carry_out;
          state        <= ST_WB;
        end
        ST_WB: begin
          if (!is_nop) begin
            carry <= result_carry;
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef COZY_EXEC_ZFLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
    end else if (state == ST_WB && !is_nop) begin
      zero <= (result == '0);
    end
  end
`endif

endmodule

// File: doc/cozy_exec_ctrl.md
Name: cozy_exec_ctrl

Overview:
- Execute-stage controller: the driving end of the cozy ALU operand/result interface.
- Accepts 16-bit ALU instruction words over a valid/ready handshake and reads rD/rS from an internal 8x16 register file.
- Drives the combinational ALU (op, operands, carry_in), then writes the result and carry flag back.
- Sits between the cozy instruction fetch/decode front end and the ALU.

Parameters:
- NREGS, 8, register-file depth; must be a power of two ≤ 8 (index fields are 3 bits).
- WIDTH, 16, datapath width; fixed to match the ALU.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word present
- in_instr  in  16  [3:0] ALU op, [6:4] rD index, [9:7] rS index, [10] no-write (compare), [15:11] reserved (must be 0)
- in_ready  out  1  controller can accept an instruction
- alu_op  out  4  op to ALU
- alu_rD  out  16  rD operand to ALU
- alu_rS  out  16  rS operand to ALU
- alu_carry_in  out  1  current carry flag to ALU
- alu_out  in  16  ALU result
- alu_carry_out  in  1  ALU carry result
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  one-cycle pulse: instruction rejected (reserved bits set)
- carry  out  1  architectural carry flag
- dbg_addr  in  3  debug read index
- dbg_data  out  16  combinational read of reg[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registers, carry, alu_op, alu_rD, alu_rS, done and err are 0.
  - in_ready=1 once reset is released.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_instr.
    - If in_instr[15:11]!=0: pulse err for one cycle, stay in IDLE, no state change.
    - Otherwise go to READ.
  - READ: register alu_rD<=reg[rD], alu_rS<=reg[rS], alu_op<=op. in_ready=0.
  - EXEC: ALU outputs settle; latch alu_out and alu_carry_out into result registers.
  - WB:
    - reg[rD]<=result unless no-write=1 or op==4'hF.
    - carry<=carry_out unless op==4'hF.
    - Pulse done for one cycle, return to IDLE.
- Latency: accept edge to done pulse is 3 cycles. Throughput is one instruction per 4 cycles; there is no overlap.
- alu_carry_in always equals the carry register; it is stable during EXEC.
- rD==rS is legal: both operands read the same value.
- op 4'hF: NOP. Nothing is written, carry is held, done still pulses.
- in_valid outside IDLE is ignored; the word is not captured.
- Reset mid-instruction aborts with no writeback, no done pulse, and carry cleared.
- dbg_data reflects a WB write on the cycle after the write edge.
- Indices ≥ NREGS wrap modulo NREGS.

Optional Feature:
- COZY_EXEC_ZFLAG_EN defined:
  - Adds output port zero (1 bit): zero flag, reset 0.
  - Updated in WB alongside carry: zero<=(result==0), except for op 4'hF.
- Not defined: the port and its logic are absent.

Decomposition:
- Shared package/header: ALU op encodings (OP_MOV=0 … OP_NEG=4'hE, OP_NOP=4'hF), instruction field bit positions, FSM state encodings.
- One natural sub-module: cozy_regfile. NREGS x 16 storage, async reset to zero, two combinational read ports plus the debug read port, one synchronous write port.

Test Plan:
- Reset: hold rst_n low -> in_ready=1 after release; dbg_data=0 for all indices; carry=0.
- Preload r1=0xFFFF and r2=0x0001 via MOV chains, then ADD rD=1,rS=2 -> done 3 cycles after accept; r1=0x0000; carry=1.
- With carry=1, ADC rD=3(0x0005),rS=4(0x0010) -> alu_carry_in=1 during EXEC; r3=0x0016; carry=0.
- Compare: SUB rD=5(0x0003),rS=6(0x0004) with no-write=1 -> r5 stays 0x0003; carry=1.
- Reserved bits: in_instr=0x8000 -> err pulses the next cycle, no done, registers unchanged, in_ready stays 1. Then op 4'hF -> done pulses, carry unchanged.
- Reset asserted during EXEC of MOV r7<-r1 -> r7 stays 0, no done pulse, FSM returns to IDLE.
